// File: rtl/regfile_onehot_wr.sv
// 32-entry register file written through a one-hot select from the address decoder.
// Two combinational read ports with optional write forwarding and a hardwired-zero top entry.
module regfile_onehot_wr #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DEPTH-1:0]         wr_sel,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr2,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [WIDTH-1:0]         rd_data2,
  output logic                     sel_err,
  output logic [7:0]               wr_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   TOP_ADDR = AW'(DEPTH - 1);
  localparam logic [DEPTH-1:0] SEL_ONE = DEPTH'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             sel_err_q, sel_err_d;
  logic [7:0]       wr_count_q, wr_count_d;

  logic sel_any, sel_multi, wr_ok;
  logic byp1, byp2, zero1, zero2;

  // Clearing the lowest set bit leaves something behind only for multi-hot selects.
  assign sel_any   = |wr_sel;
  assign sel_multi = (wr_sel & (wr_sel - SEL_ONE)) != '0;
  assign wr_ok     = sel_any && !sel_multi && !(ZERO_REG && wr_sel[DEPTH-1]);

  always_comb begin
    sel_err_d  = sel_err_q | sel_multi;
    wr_count_d = wr_count_q;
    if (wr_ok && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      sel_err_q  <= 1'b0;
      wr_count_q <= 8'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && wr_sel[i]) begin
          mem_q[i] <= wr_data;
        end
      end
      sel_err_q  <= sel_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Forwarding is blocked during reset so the ports show the cleared array.
  assign byp1  = BYPASS && !reset && wr_ok && wr_sel[rd_addr1];
  assign byp2  = BYPASS && !reset && wr_ok && wr_sel[rd_addr2];
  assign zero1 = ZERO_REG && (rd_addr1 == TOP_ADDR);
  assign zero2 = ZERO_REG && (rd_addr2 == TOP_ADDR);

  assign rd_data1 = zero1 ? '0 : (byp1 ? wr_data : mem_q[rd_addr1]);
  assign rd_data2 = zero2 ? '0 : (byp2 ? wr_data : mem_q[rd_addr2]);

  assign sel_err  = sel_err_q;
  assign wr_count = wr_count_q;

endmodule
